// File: rtl/netwalk_dpl_pkg.sv
// Shared constants and state encoding for the netwalk data-plane ingress path.
package netwalk_dpl_pkg;

    localparam int IN_DATA_WIDTH      = 64;
    localparam int DPL_PKT_BIT_WIDTH  = 512;
    localparam int INGRESS_PORT_WIDTH = 32;
    localparam int PKT_LEN_WIDTH      = 16;
    localparam int DROP_CNT_WIDTH     = 16;

    // Number of receive words that fit in one classifier header.
    localparam int HDR_WORDS = DPL_PKT_BIT_WIDTH / IN_DATA_WIDTH;

    // Assembler state encoding, fixed so external monitors can decode it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } dpl_state_t;

endpackage

// File: rtl/netwalk_eop_byte_mask.sv
// Turns an end-of-packet byte count into a keep-mask over a 64-bit word.
// Byte 0 of the word sits in [63:56]; a count of 0 or above 8 means a full word.
module netwalk_eop_byte_mask
    import netwalk_dpl_pkg::*;
(
    input  logic [3:0]               i_bytes_valid,
    output logic [IN_DATA_WIDTH-1:0] o_keep_mask,
    output logic [3:0]               o_byte_cnt
);

    logic [3:0] w_cnt;

    // Normalise the count and open one byte lane per valid byte, from the top down.
    always_comb begin
        w_cnt = 4'd8;
        if ((i_bytes_valid != 4'd0) && (i_bytes_valid <= 4'd8)) begin
            w_cnt = i_bytes_valid;
        end
        o_keep_mask = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < w_cnt) begin
                o_keep_mask[IN_DATA_WIDTH-1-8*b -: 8] = 8'hFF;
            end
        end
        o_byte_cnt = w_cnt;
    end

endmodule

// File: rtl/netwalk_pkt_header_assembler.sv
// Packs the first 64 bytes of each received packet into a 512-bit header for
// the classifier, tracks packet length and counts malformed-frame events.
//
// Handshakes: on the receive side a word moves on any rising edge where
// rx_valid & rx_ready; rx_ready is registered and is low only in PRESENT (and
// during reset). On the classifier side the header is offered while
// pkt_header_ready is high and is consumed on the edge where
// pkt_header_accept is also high; header, port and length hold until then.
module netwalk_pkt_header_assembler
    import netwalk_dpl_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic [IN_DATA_WIDTH-1:0]      rx_data,
    input  logic                          rx_sop,
    input  logic                          rx_eop,
    input  logic [3:0]                    rx_bytes_valid,
    input  logic [INGRESS_PORT_WIDTH-1:0] rx_ingress_port,
    output logic                          pkt_header_ready,
    input  logic                          pkt_header_accept,
    output logic [DPL_PKT_BIT_WIDTH-1:0]  pkt_header_data,
    output logic [INGRESS_PORT_WIDTH-1:0] pkt_ingress_port,
    output logic [PKT_LEN_WIDTH-1:0]      pkt_length,
    output logic [DROP_CNT_WIDTH-1:0]     pkt_drop_count
);

    dpl_state_t                    r_state;
    logic                          r_rx_ready;
    logic                          r_hdr_ready;
    logic [DPL_PKT_BIT_WIDTH-1:0]  r_header;
    logic [INGRESS_PORT_WIDTH-1:0] r_port;
    logic [PKT_LEN_WIDTH-1:0]      r_len;
    logic [DROP_CNT_WIDTH-1:0]     r_drop;
    logic [3:0]                    r_word_cnt;

    logic [IN_DATA_WIDTH-1:0]      w_keep;
    logic [3:0]                    w_eop_cnt;
    logic [3:0]                    w_bytes;
    logic [IN_DATA_WIDTH-1:0]      w_word;
    logic                          w_xfer;
    logic [PKT_LEN_WIDTH:0]        w_len_sum;
    logic [PKT_LEN_WIDTH-1:0]      w_len_next;
    logic [DROP_CNT_WIDTH-1:0]     w_drop_next;
    logic                          w_last_slot;

    netwalk_eop_byte_mask u_eop_mask (
        .i_bytes_valid (rx_bytes_valid),
        .o_keep_mask   (w_keep),
        .o_byte_cnt    (w_eop_cnt)
    );

    // Per-word byte count, masked data and saturating counter updates.
    always_comb begin
        w_xfer      = rx_valid & r_rx_ready;
        w_bytes     = rx_eop ? w_eop_cnt : 4'd8;
        w_word      = rx_eop ? (rx_data & w_keep) : rx_data;
        w_len_sum   = {1'b0, r_len} + (PKT_LEN_WIDTH+1)'(w_bytes);
        w_len_next  = w_len_sum[PKT_LEN_WIDTH] ? '1 : w_len_sum[PKT_LEN_WIDTH-1:0];
        w_drop_next = (r_drop == '1) ? r_drop : r_drop + 1'b1;
        w_last_slot = (r_word_cnt == 4'(HDR_WORDS - 1));
    end

    // Assembler FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_hdr_ready <= 1'b0;
            r_header    <= '0;
            r_port      <= '0;
            r_len       <= '0;
            r_drop      <= '0;
            r_word_cnt  <= '0;
        end else begin
            case (r_state)
                ST_PRESENT: begin
                    r_rx_ready <= 1'b0;
                    if (pkt_header_accept) begin
                        r_state     <= ST_IDLE;
                        r_hdr_ready <= 1'b0;
                        r_rx_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_rx_ready <= 1'b1;
                    if (w_xfer) begin
                        if (rx_sop) begin
                            // A sop outside IDLE means the previous packet never ended.
                            if (r_state != ST_IDLE) begin
                                r_drop <= w_drop_next;
                            end
                            r_header   <= {w_word, {(DPL_PKT_BIT_WIDTH-IN_DATA_WIDTH){1'b0}}};
                            r_word_cnt <= 4'd1;
                            r_port     <= rx_ingress_port;
                            r_len      <= PKT_LEN_WIDTH'(w_bytes);
                            r_state    <= ST_COLLECT;
                        end else if (r_state == ST_IDLE) begin
                            r_drop <= w_drop_next;
                        end else begin
                            r_len <= w_len_next;
                            if (r_state == ST_COLLECT) begin
                                for (int k = 1; k < HDR_WORDS; k++) begin
                                    if (r_word_cnt == 4'(k)) begin
                                        r_header[DPL_PKT_BIT_WIDTH-1-IN_DATA_WIDTH*k -: IN_DATA_WIDTH] <= w_word;
                                    end
                                end
                                r_word_cnt <= r_word_cnt + 4'd1;
                                if (w_last_slot) begin
                                    r_state <= ST_DRAIN;
                                end
                            end
                        end
                        // eop closes the packet whichever state it arrived in.
                        if (rx_eop && (rx_sop || (r_state != ST_IDLE))) begin
                            r_state     <= ST_PRESENT;
                            r_hdr_ready <= 1'b1;
                            r_rx_ready  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign rx_ready         = r_rx_ready;
    assign pkt_header_ready = r_hdr_ready;
    assign pkt_header_data  = r_header;
    assign pkt_ingress_port = r_port;
    assign pkt_length       = r_len;
    assign pkt_drop_count   = r_drop;

endmodule
